vga_text_writer: RTL and testbench

- Character-stream controller that owns the write port of the VGA text buffer (80x30 tiles, 2400 byte-addressed character cells).
- Accepts ASCII bytes on a valid/ready stream, keeps a hardware cursor, and generates buffer writes for printable characters and control codes (CR, LF, BS, FF).
- Sequences multi-word fill operations: clear one row, or clear the whole screen.
- Arbitrates the single buffer write port between its own engine and the AXI-lite host write path, with bounded host priority.

---
 rtl/vga_text_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_text_writer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_writer.sv
// Character-stream cursor engine and write-port arbiter for the 80x30 VGA text buffer; registered writes one cycle after grant.
// Stream is backpressured (char_ready_o low) while any engine write is pending; host is stalled at most one cycle after MAX_HOST_BURST grants.
module vga_text_writer #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          DATA_WIDTH     = 32,
    parameter int          N_COL          = 80,
    parameter int          N_ROW          = 30,
    parameter int          MAX_HOST_BURST = 8,
    parameter logic [7:0]  FILL_CHAR      = 8'h20
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    char_valid_i,
    input  logic [7:0]              char_data_i,
    output logic                    char_ready_o,
    input  logic                    host_wr_i,
    input  logic [ADDR_WIDTH-1:0]   host_waddr_i,
    input  logic [DATA_WIDTH-1:0]   host_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] host_wstrb_i,
    output logic                    host_ready_o,
    output logic                    buf_wr_o,
    output logic [ADDR_WIDTH-1:0]   buf_waddr_o,
    output logic [DATA_WIDTH-1:0]   buf_wdata_o,
    output logic [DATA_WIDTH/8-1:0] buf_wstrb_o,
    output logic [6:0]              cursor_col_o,
    output logic [4:0]              cursor_row_o,
    output logic                    busy_o
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int ROW_WORDS = N_COL / LANES;
    localparam int ALL_WORDS = (N_COL * N_ROW) / LANES;
    localparam int IDX_W     = $clog2(ALL_WORDS);
    localparam int STREAK_W  = $clog2(MAX_HOST_BURST + 1);

    typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_ROW, CLR_ALL} state_t;

    state_t                 state, state_nxt;
    logic [6:0]             col, col_nxt;
    logic [4:0]             row, row_nxt;
    logic [6:0]             pend_col, pend_col_nxt;
    logic [4:0]             pend_row, pend_row_nxt;
    logic [4:0]             clr_row, clr_row_nxt;
    logic                   clr_after, clr_after_nxt;
    logic [ADDR_WIDTH-1:0]  chr_addr, chr_addr_nxt;
    logic [7:0]             chr_byte, chr_byte_nxt;
    logic [IDX_W-1:0]       clr_idx, clr_idx_nxt;
    logic [STREAK_W-1:0]    streak;

    logic                   pending, host_grant, eng_grant, accept, printable;
    logic [4:0]             row_adv;
    logic [ADDR_WIDTH-1:0]  cell_addr, row_base;
    logic [ADDR_WIDTH-1:0]  eng_addr;
    logic [DATA_WIDTH-1:0]  eng_data;
    logic [LANES-1:0]       eng_strb;

    assign pending      = (state != IDLE);
    assign busy_o       = pending;
    assign char_ready_o = (state == IDLE) && !rst_i;
    assign host_ready_o = !(pending && (streak == STREAK_W'(MAX_HOST_BURST)));
    assign host_grant   = host_wr_i && host_ready_o;
    assign eng_grant    = pending && !host_grant;
    assign accept       = char_valid_i && char_ready_o;
    assign printable    = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);

    assign row_adv   = (row == 5'(N_ROW - 1)) ? 5'd0 : row + 5'd1;
    assign cell_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(N_COL) + ADDR_WIDTH'(col);
    assign row_base  = ADDR_WIDTH'(clr_row) * ADDR_WIDTH'(N_COL);

    assign cursor_col_o = col;
    assign cursor_row_o = row;

    always_comb begin
        eng_addr = '0;
        eng_strb = '0;
        eng_data = '0;
        case (state)
            WR_CHAR: begin
                eng_addr = chr_addr;
                eng_strb = LANES'(1) << chr_addr[LANE_BITS-1:0];
                eng_data = {LANES{chr_byte}};
            end
            CLR_ROW: begin
                eng_addr = row_base + ADDR_WIDTH'(clr_idx) * ADDR_WIDTH'(LANES);
                eng_strb = '1;
                eng_data = {LANES{FILL_CHAR}};
            end
            CLR_ALL: begin
                eng_addr = ADDR_WIDTH'(clr_idx) * ADDR_WIDTH'(LANES);
                eng_strb = '1;
                eng_data = {LANES{FILL_CHAR}};
            end
            default: ;
        endcase
    end

    // Visible cursor only moves when the whole operation retires; pend_* holds where it lands.
    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        pend_col_nxt  = pend_col;
        pend_row_nxt  = pend_row;
        clr_row_nxt   = clr_row;
        clr_after_nxt = clr_after;
        chr_addr_nxt  = chr_addr;
        chr_byte_nxt  = chr_byte;
        clr_idx_nxt   = clr_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        state_nxt    = WR_CHAR;
                        chr_addr_nxt = cell_addr;
                        chr_byte_nxt = char_data_i;
                        if (col == 7'(N_COL - 1)) begin
                            pend_col_nxt  = '0;
                            pend_row_nxt  = row_adv;
                            clr_row_nxt   = row_adv;
                            clr_after_nxt = 1'b1;
                        end else begin
                            pend_col_nxt  = col + 7'd1;
                            pend_row_nxt  = row;
                            clr_after_nxt = 1'b0;
                        end
                    end else begin
                        case (char_data_i)
                            8'h0D: col_nxt = '0;
                            8'h0A: begin
                                state_nxt    = CLR_ROW;
                                clr_idx_nxt  = '0;
                                clr_row_nxt  = row_adv;
                                pend_col_nxt = '0;
                                pend_row_nxt = row_adv;
                            end
                            8'h08: begin
                                if (col != 7'd0) begin
                                    state_nxt     = WR_CHAR;
                                    chr_addr_nxt  = cell_addr - ADDR_WIDTH'(1);
                                    chr_byte_nxt  = FILL_CHAR;
                                    pend_col_nxt  = col - 7'd1;
                                    pend_row_nxt  = row;
                                    clr_after_nxt = 1'b0;
                                end
                            end
                            8'h0C: begin
                                state_nxt    = CLR_ALL;
                                clr_idx_nxt  = '0;
                                pend_col_nxt = '0;
                                pend_row_nxt = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WR_CHAR: begin
                if (eng_grant) begin
                    if (clr_after) begin
                        state_nxt   = CLR_ROW;
                        clr_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        col_nxt   = pend_col;
                        row_nxt   = pend_row;
                    end
                end
            end
            CLR_ROW: begin
                if (eng_grant) begin
                    if (clr_idx == IDX_W'(ROW_WORDS - 1)) begin
                        state_nxt = IDLE;
                        col_nxt   = pend_col;
                        row_nxt   = pend_row;
                    end else begin
                        clr_idx_nxt = clr_idx + IDX_W'(1);
                    end
                end
            end
            CLR_ALL: begin
                if (eng_grant) begin
                    if (clr_idx == IDX_W'(ALL_WORDS - 1)) begin
                        state_nxt = IDLE;
                        col_nxt   = pend_col;
                        row_nxt   = pend_row;
                    end else begin
                        clr_idx_nxt = clr_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            pend_col    <= '0;
            pend_row    <= '0;
            clr_row     <= '0;
            clr_after   <= 1'b0;
            chr_addr    <= '0;
            chr_byte    <= '0;
            clr_idx     <= '0;
            streak      <= '0;
            buf_wr_o    <= 1'b0;
            buf_waddr_o <= '0;
            buf_wdata_o <= '0;
            buf_wstrb_o <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            pend_col  <= pend_col_nxt;
            pend_row  <= pend_row_nxt;
            clr_row   <= clr_row_nxt;
            clr_after <= clr_after_nxt;
            chr_addr  <= chr_addr_nxt;
            chr_byte  <= chr_byte_nxt;
            clr_idx   <= clr_idx_nxt;

            if (!pending || eng_grant) begin
                streak <= '0;
            end else if (host_grant) begin
                streak <= streak + STREAK_W'(1);
            end

            buf_wr_o <= host_grant || eng_grant;
            if (host_grant) begin
                buf_waddr_o <= host_waddr_i;
                buf_wdata_o <= host_wdata_i;
                buf_wstrb_o <= host_wstrb_i;
            end else if (eng_grant) begin
                buf_waddr_o <= eng_addr;
                buf_wdata_o <= eng_data;
                buf_wstrb_o <= eng_strb;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: random and directed byte streams checked against a cell/cursor reference model.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = '0;
    logic        char_ready;
    logic        host_wr = 1'b0;
    logic [11:0] host_waddr = '0;
    logic [31:0] host_wdata = '0;
    logic [3:0]  host_wstrb = '0;
    logic        host_ready;
    logic        buf_wr;
    logic [11:0] buf_waddr;
    logic [31:0] buf_wdata;
    logic [3:0]  buf_wstrb;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    vga_text_writer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .char_valid_i (char_valid),
        .char_data_i  (char_data),
        .char_ready_o (char_ready),
        .host_wr_i    (host_wr),
        .host_waddr_i (host_waddr),
        .host_wdata_i (host_wdata),
        .host_wstrb_i (host_wstrb),
        .host_ready_o (host_ready),
        .buf_wr_o     (buf_wr),
        .buf_waddr_o  (buf_waddr),
        .buf_wdata_o  (buf_wdata),
        .buf_wstrb_o  (buf_wstrb),
        .cursor_col_o (cursor_col),
        .cursor_row_o (cursor_row),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t host_q[$];
    int  total = 0;
    int  bad = 0;
    int  m_col = 0;
    int  m_row = 0;
    int  hr_low = 0;

    always @(negedge clk) begin
        if (buf_wr === 1'b1) obs_q.push_back(wr_t'({buf_waddr, buf_wstrb, buf_wdata}));
        if (host_ready === 1'b0) hr_low++;
    end

    function automatic wr_t mk(input int addr, input logic [3:0] s, input logic [31:0] d);
        wr_t w;
        w.addr = 12'(addr);
        w.strb = s;
        w.data = d;
        return w;
    endfunction

    function automatic void push_char(input int addr, input logic [7:0] b);
        logic [3:0] s;
        s = 4'b0001 << (addr % 4);
        exp_q.push_back(mk(addr, s, {4{b}}));
    endfunction

    function automatic void push_clear(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(base + 4 * i, 4'hF, 32'h20202020));
    endfunction

    // Screen semantics: what each byte should write and where the cursor ends up.
    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_char(m_row * 80 + m_col, b);
            m_col++;
            if (m_col == 80) begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
                push_clear(m_row * 80, 20);
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 30;
            push_clear(m_row * 80, 20);
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_char(m_row * 80 + m_col, 8'h20);
            end
        end else if (b == 8'h0C) begin
            push_clear(0, 600);
            m_col = 0;
            m_row = 0;
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int count_eng();
        int c = 0;
        foreach (obs_q[i]) if (obs_q[i].data == 32'h20202020 && obs_q[i].strb == 4'hF) c++;
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        char_valid = 1'b1;
        char_data  = b;
        model_apply(b);
        @(negedge clk);
        char_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL send_timeout: byte %02h busy=%0b after %0d cycles, required 0", b, busy, n);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (char_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b required 0", char_ready); end
        total++; if (buf_wr !== 1'b0) begin bad++; $display("FAIL reset_buf_wr: got %0b required 0", buf_wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row); end
        total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %0b required 1", char_ready); end
        total++; if ({buf_waddr, buf_wdata, buf_wstrb} !== 48'd0) begin bad++; $display("FAIL reset_buf_bus: got %h/%h/%h required 0", buf_waddr, buf_wdata, buf_wstrb); end
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_host_ready: got %0b required 1", host_ready); end
        m_col = 0; m_row = 0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_latency();
        int d;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = 8'h41;
        model_apply(8'h41);
        @(negedge clk);
        char_valid = 1'b0;
        total++; if (busy !== 1'b1 || char_ready !== 1'b0 || buf_wr !== 1'b0) begin
            bad++; $display("FAIL lat_accept: busy/ready/wr got %0b/%0b/%0b required 1/0/0", busy, char_ready, buf_wr); end
        @(negedge clk);
        total++; if (buf_wr !== 1'b1 || buf_waddr !== 12'd0 || buf_wstrb !== 4'b0001 || buf_wdata !== 32'h41414141) begin
            bad++; $display("FAIL lat_write: got wr=%0b addr=%0d strb=%b data=%h required 1/0/0001/41414141", buf_wr, buf_waddr, buf_wstrb, buf_wdata); end
        total++; if (char_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL lat_ready: ready/busy got %0b/%0b required 1/0", char_ready, busy); end
        total++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
            bad++; $display("FAIL lat_cursor: got (%0d,%0d) required (1,0)", cursor_col, cursor_row); end
        @(negedge clk);
        total++; if (buf_wr !== 1'b0) begin bad++; $display("FAIL lat_pulse: buf_wr got %0b required 0", buf_wr); end
        @(negedge clk);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL lat_writes: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        int d;
        repeat (78) send_byte(8'($urandom_range(32, 126)));
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL wrap_fill: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (cursor_col !== 7'd79 || cursor_row !== 5'd0) begin bad++; $display("FAIL wrap_pre_cursor: got (%0d,%0d) required (79,0)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
        send_byte(8'h5A);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL wrap_writes: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (obs_q.size() != 21 || obs_q[0] !== mk(79, 4'b1000, 32'h5A5A5A5A) || obs_q[20].addr !== 12'd156) begin
            bad++; $display("FAIL wrap_shape: got %0d writes required 21 (char at 79, last clear at 156)", obs_q.size()); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_lf_wrap();
        int d;
        repeat (28) send_byte(8'h0A);
        repeat (5) send_byte(8'($urandom_range(32, 126)));
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL lf_setup: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (cursor_col !== 7'd5 || cursor_row !== 5'd29) begin bad++; $display("FAIL lf_pre_cursor: got (%0d,%0d) required (5,29)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
        send_byte(8'h0A);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL lf_writes: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (obs_q.size() != 20 || obs_q[0].addr !== 12'd0 || obs_q[19].addr !== 12'd76) begin
            bad++; $display("FAIL lf_range: got %0d writes required 20 spanning 0..76", obs_q.size()); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("FAIL lf_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
        send_byte(8'h08);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bs_col0_writes: got %0d writes required 0", obs_q.size()); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("FAIL bs_col0_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_ff();
        int n, viol, d;
        send_byte(8'h61);
        send_byte(8'h62);
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = 8'h0C;
        model_apply(8'h0C);
        n = 0; viol = 0;
        @(negedge clk);
        char_valid = 1'b0;
        while (obs_q.size() < 600 && n < 3000) begin
            if (obs_q.size() < 599 && (busy !== 1'b1 || char_ready !== 1'b0 || cursor_col !== 7'd2 || cursor_row !== 5'd0)) viol++;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        total++; if (viol != 0) begin bad++; $display("FAIL ff_busy_hold: %0d cycles with busy/ready/cursor wrong, required 0", viol); end
        total++; if (obs_q.size() != 600) begin bad++; $display("FAIL ff_count: got %0d writes required 600", obs_q.size()); end
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL ff_writes: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b0 || char_ready !== 1'b1) begin
            bad++; $display("FAIL ff_done: cursor (%0d,%0d) busy %0b ready %0b required (0,0) 0 1", cursor_col, cursor_row, busy, char_ready); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_host_burst();
        int  n, hr0, bad_gap;
        bit  stop;
        int  pos[$];
        wr_t eng_obs[$];
        wr_t host_obs[$];
        obs_q.delete(); exp_q.delete(); host_q.delete();
        hr0 = hr_low;
        stop = 1'b0;
        fork
            begin
                bit  acc;
                wr_t item;
                acc = 1'b1;
                while (!stop) begin
                    @(negedge clk);
                    if (stop) break;
                    if (acc) item = mk($urandom_range(0, 4095), 4'($urandom_range(1, 15)), $urandom | 32'h8000_0000);
                    host_wr    = 1'b1;
                    host_waddr = item.addr;
                    host_wstrb = item.strb;
                    host_wdata = item.data;
                    acc = host_ready;
                    if (acc) host_q.push_back(item);
                end
                host_wr = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                char_valid = 1'b1;
                char_data  = 8'h0A;
                model_apply(8'h0A);
                @(negedge clk);
                char_valid = 1'b0;
                n = 0;
                while (count_eng() < 20 && n < 1000) begin @(negedge clk); n++; end
                stop = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        foreach (obs_q[i]) begin
            if (obs_q[i].data == 32'h20202020 && obs_q[i].strb == 4'hF) begin
                pos.push_back(i);
                eng_obs.push_back(obs_q[i]);
            end else begin
                host_obs.push_back(obs_q[i]);
            end
        end
        total++; if (eng_obs.size() != exp_q.size() || eng_obs != exp_q) begin
            bad++; $display("FAIL burst_engine: got %0d engine writes required %0d matching row clear", eng_obs.size(), exp_q.size()); end
        total++; if (host_obs.size() != host_q.size() || host_obs != host_q) begin
            bad++; $display("FAIL burst_host_data: got %0d host writes required %0d unmodified", host_obs.size(), host_q.size()); end
        bad_gap = 0;
        for (int k = 1; k < pos.size(); k++) if (pos[k] - pos[k-1] - 1 != 8) bad_gap++;
        total++; if (bad_gap != 0 || pos.size() == 0 || pos[0] < 8) begin
            bad++; $display("FAIL burst_pattern: %0d gaps not 8 host writes (of %0d engine writes), required 0", bad_gap, pos.size()); end
        total++; if (hr_low - hr0 != 20) begin bad++; $display("FAIL burst_host_ready_low: got %0d cycles required 20", hr_low - hr0); end
        total++; if (cursor_col !== 7'(m_col) || cursor_row !== 5'(m_row)) begin
            bad++; $display("FAIL burst_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_col, cursor_row, m_col, m_row); end
        obs_q.delete(); exp_q.delete(); host_q.delete();
    endtask

    task automatic test_random();
        int d, r;
        logic [7:0] b;
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 68)      b = 8'($urandom_range(32, 126));
            else if (r < 76) b = 8'h0D;
            else if (r < 84) b = 8'h0A;
            else if (r < 94) b = 8'h08;
            else if (r < 97) b = 8'($urandom_range(127, 255));
            else             b = 8'h0C;
            send_byte(b);
            d = first_diff();
            total++; if (d != -1) begin bad++; $display("FAIL rand_writes: byte %02h iter %0d differ at %0d, got %0d writes expected %0d", b, it, d, obs_q.size(), exp_q.size()); end
            total++; if (cursor_col !== 7'(m_col) || cursor_row !== 5'(m_row)) begin
                bad++; $display("FAIL rand_cursor: byte %02h iter %0d got (%0d,%0d) required (%0d,%0d)", b, it, cursor_col, cursor_row, m_col, m_row); end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int n, sz, d;
        send_byte(8'h51);
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = 8'h0C;
        @(negedge clk);
        char_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 100 && n < 1000) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        total++; if (buf_wr !== 1'b0 || char_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_immediate: wr/ready got %0b/%0b required 0/0 (writes seen %0d)", buf_wr, char_ready, obs_q.size()); end
        sz = obs_q.size();
        repeat (5) @(negedge clk);
        total++; if (obs_q.size() != sz) begin bad++; $display("FAIL rstmid_no_writes: got %0d writes required %0d", obs_q.size(), sz); end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (obs_q.size() != sz) begin bad++; $display("FAIL rstmid_after_release: got %0d writes required %0d", obs_q.size(), sz); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b0 || char_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state: cursor (%0d,%0d) busy %0b ready %0b required (0,0) 0 1", cursor_col, cursor_row, busy, char_ready); end
        m_col = 0; m_row = 0;
        obs_q.delete(); exp_q.delete();
        send_byte(8'h41);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL rstmid_resume: differ at %0d, got %0d writes expected %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin bad++; $display("FAIL rstmid_resume_cursor: got (%0d,%0d) required (1,0)", cursor_col, cursor_row); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_lf_wrap();
        test_ff();
        test_host_burst();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
